// File: rtl/xsim_msg_deframer.sv
// xsim_msg_deframer: splits a 32-bit beat stream into header-framed messages
// and queues one FIFO entry per payload word (or one entry for a header-only
// message). Malformed headers are counted; oversized messages are skipped.
module xsim_msg_deframer #(
  parameter int DEPTH     = 4,
  parameter int MAX_WORDS = 256
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        src_rdy,
  input  logic [31:0] beat,
  output logic        in_ready,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic [15:0] msg_method,
  output logic [31:0] msg_data,
  output logic        msg_first,
  output logic        msg_last,
  output logic        msg_empty,
  output logic [31:0] msg_count,
  output logic [15:0] err_count,
  output logic [1:0]  o_dbg_state
);

  // Handshake rules: a transfer happens on a rising CLK edge where valid and
  // ready are both high (src_rdy/in_ready upstream, msg_valid/msg_ready
  // downstream). A producer keeps valid and its data steady until that edge;
  // ready never depends combinationally on the other side's valid.

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [31:0] LP_MAX  = 32'(MAX_WORDS);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] method;
    logic [31:0] data;
    logic        first;
    logic        last;
    logic        empty;
  } entry_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_rem;
  logic [15:0] w_rem_nxt;
  logic [15:0] r_method;
  logic [15:0] w_method_nxt;
  logic        r_first;
  logic        w_first_nxt;
  logic        r_rdy_en;
  logic [31:0] r_msg_count;
  logic [15:0] r_err_count;

  entry_t      r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic        w_full;
  logic        w_fifo_empty;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_pop;
  logic        w_push;
  entry_t      w_push_entry;
  entry_t      w_head;
  logic        w_msg_inc;
  logic        w_err_inc;
  logic [15:0] w_len;
  logic [15:0] w_hdr_method;

  assign w_len        = beat[15:0];
  assign w_hdr_method = beat[31:16];

  // Extra pointer bit distinguishes full from empty when indices match.
  assign w_fifo_empty = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[AW] != r_rptr[AW]) &&
                        (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // DROP never writes the FIFO, so it can always take beats; no bypass of a full FIFO.
  assign w_in_ready = r_rdy_en & ((r_state == ST_DROP) | ~w_full);
  assign w_accept   = src_rdy & w_in_ready;
  assign w_pop      = ~w_fifo_empty & msg_ready;

  // Next-state and push decode for the framing FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_method_nxt = r_method;
    w_first_nxt  = r_first;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_msg_inc    = 1'b0;
    w_err_inc    = 1'b0;
    case (r_state)
      ST_HDR: begin
        if (w_accept) begin
          if (w_len == 16'd0) begin
            w_err_inc = 1'b1;
          end else if ({16'd0, w_len} > LP_MAX) begin
            w_err_inc   = 1'b1;
            w_rem_nxt   = w_len - 16'd1;
            w_state_nxt = ST_DROP;
          end else if (w_len == 16'd1) begin
            w_push       = 1'b1;
            w_push_entry = '{method: w_hdr_method, data: 32'd0,
                             first: 1'b1, last: 1'b1, empty: 1'b1};
            w_msg_inc    = 1'b1;
          end else begin
            w_method_nxt = w_hdr_method;
            w_rem_nxt    = w_len - 16'd1;
            w_first_nxt  = 1'b1;
            w_state_nxt  = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_accept) begin
          w_push       = 1'b1;
          w_push_entry = '{method: r_method, data: beat, first: r_first,
                           last: (r_rem == 16'd1), empty: 1'b0};
          w_first_nxt  = 1'b0;
          w_rem_nxt    = r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            w_msg_inc   = 1'b1;
            w_state_nxt = ST_HDR;
          end
        end
      end
      ST_DROP: begin
        if (w_accept) begin
          w_rem_nxt = r_rem - 16'd1;
          if (r_rem == 16'd1) begin
            w_state_nxt = ST_HDR;
          end
        end
      end
      default: begin
        w_state_nxt = ST_HDR;
      end
    endcase
  end

  // FSM state, framing context, counters and FIFO pointers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_HDR;
      r_rem       <= 16'd0;
      r_method    <= 16'd0;
      r_first     <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_msg_count <= 32'd0;
      r_err_count <= 16'd0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rem       <= w_rem_nxt;
      r_method    <= w_method_nxt;
      r_first     <= w_first_nxt;
      r_rdy_en    <= 1'b1;
      r_msg_count <= r_msg_count + {31'd0, w_msg_inc};
      if (w_err_inc && (r_err_count != 16'hFFFF)) begin
        r_err_count <= r_err_count + 16'd1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are meaningless until the write pointer covers them.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_push_entry;
    end
  end

  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign in_ready    = w_in_ready;
  assign msg_valid   = ~w_fifo_empty;
  assign msg_method  = msg_valid ? w_head.method : 16'd0;
  assign msg_data    = msg_valid ? w_head.data   : 32'd0;
  assign msg_first   = msg_valid & w_head.first;
  assign msg_last    = msg_valid & w_head.last;
  assign msg_empty   = msg_valid & w_head.empty;
  assign msg_count   = r_msg_count;
  assign err_count   = r_err_count;
  assign o_dbg_state = r_state;

endmodule
